// File: rtl/alu_nibble_seq_if.sv
// rtl/alu_nibble_seq_if.sv - control and nibble-slice bus for alu_nibble_seq
// Optional zero flag is present when ALU_NIBBLE_SEQ_ZERO_FLAG_EN is defined.
interface alu_nibble_seq_if #(parameter int WORDS = 2);
  localparam int W = 8 * WORDS;

  logic         start;
  logic [3:0]   op;
  logic         invert;
  logic         carry_in;
  logic         shift_in;
  logic         msb_first;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic [3:0]   slice_op;
  logic         slice_invert;
  logic         slice_carry_in;
  logic         slice_from_hi;
  logic [3:0]   slice_result;
  logic         slice_carry_out;
  logic         slice_to_hi;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  modport slave (
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
    output zero,
`endif
    input  start, op, invert, carry_in, shift_in, msb_first, a_in, b_in,
    input  slice_result, slice_carry_out, slice_to_hi,
    output busy, done, result, carry_out,
    output slice_a, slice_b, slice_op, slice_invert, slice_carry_in, slice_from_hi
  );

  modport master (
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
    input  zero,
`endif
    output start, op, invert, carry_in, shift_in, msb_first, a_in, b_in,
    output slice_result, slice_carry_out, slice_to_hi,
    input  busy, done, result, carry_out,
    input  slice_a, slice_b, slice_op, slice_invert, slice_carry_in, slice_from_hi
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - sequences a WORDS-byte ALU op through one 4-bit slice, one nibble per clock
// Optional zero flag: define ALU_NIBBLE_SEQ_ZERO_FLAG_EN.
module alu_nibble_seq #(
  parameter int WORDS = 2
) (
  input logic             clock,
  input logic             reset,
  alu_nibble_seq_if.slave bus
);
  localparam int W   = 8 * WORDS;
  localparam int NIB = 2 * WORDS;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [IW-1:0] r_index;
  logic          r_link;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_shadow;
  logic [W-1:0]  r_result;
  logic [3:0]    r_op;
  logic          r_inv;
  logic          r_msb;
  logic          r_cin;
  logic          r_busy;
  logic          r_done;
  logic          r_carry_out;
  logic [3:0]    r_slice_a;
  logic [3:0]    r_slice_b;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
  logic          r_zero;
`endif

  logic [IW-1:0] w_cur_n;
  logic [IW-1:0] w_next_n;
  logic [IW-1:0] w_first_n;
  logic [W-1:0]  w_shadow_upd;
  logic          w_link_next;

  function automatic logic [3:0] nib_of(input logic [W-1:0] v, input logic [IW-1:0] n);
    return v[{n, 2'b00} +: 4];
  endfunction

  always_comb begin
    w_cur_n      = r_msb ? (LAST - r_index) : r_index;
    w_next_n     = r_msb ? (w_cur_n - IW'(1)) : (w_cur_n + IW'(1));
    w_first_n    = bus.msb_first ? LAST : '0;
    w_link_next  = r_msb ? bus.slice_to_hi : bus.slice_carry_out;
    w_shadow_upd = r_shadow;
    w_shadow_upd[{w_cur_n, 2'b00} +: 4] = bus.slice_result;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_index     <= '0;
      r_link      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_shadow    <= '0;
      r_result    <= '0;
      r_op        <= '0;
      r_inv       <= 1'b0;
      r_msb       <= 1'b0;
      r_cin       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_carry_out <= 1'b0;
      r_slice_a   <= '0;
      r_slice_b   <= '0;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
      r_zero      <= 1'b0;
`endif
    end else begin
      case (r_state)
        RUN: begin
          r_shadow <= w_shadow_upd;
          r_link   <= w_link_next;
          if (r_index == LAST) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_index     <= '0;
            r_result    <= w_shadow_upd;
            r_carry_out <= w_link_next;
            r_slice_a   <= '0;
            r_slice_b   <= '0;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
            r_zero      <= (w_shadow_upd == '0);
`endif
          end else begin
            r_index   <= r_index + IW'(1);
            r_slice_a <= nib_of(r_a, w_next_n);
            r_slice_b <= nib_of(r_b, w_next_n);
          end
        end
        default: begin
          // IDLE and DONE both accept a new start; DONE never lingers.
          r_done <= 1'b0;
          if (bus.start) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_a       <= bus.a_in;
            r_b       <= bus.b_in;
            r_op      <= bus.op;
            r_inv     <= bus.invert;
            r_msb     <= bus.msb_first;
            r_cin     <= bus.carry_in;
            r_index   <= '0;
            r_link    <= bus.msb_first ? bus.shift_in : bus.carry_in;
            r_slice_a <= nib_of(bus.a_in, w_first_n);
            r_slice_b <= nib_of(bus.b_in, w_first_n);
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  // The link rides on carry for LSB-first and on from_hi for MSB-first.
  assign bus.slice_carry_in = r_busy & (r_msb ? r_cin : r_link);
  assign bus.slice_from_hi  = r_busy & r_msb & r_link;
  assign bus.slice_a        = r_slice_a;
  assign bus.slice_b        = r_slice_b;
  assign bus.slice_op       = r_op;
  assign bus.slice_invert   = r_inv;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.result         = r_result;
  assign bus.carry_out      = r_carry_out;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
  assign bus.zero           = r_zero;
`endif
endmodule
